// File: rtl/rdout_lms_seq.sv
// Time-multiplexed LMS readout: one shared MAC computes est = W.x over N cycles,
// then (in TRAIN mode) applies w[i] += mu*(y - est)*x[i] over N more cycles.
module rdout_lms_seq #(
  parameter int N   = 8,
  parameter int XW  = 16,
  parameter int XF  = 12,
  parameter int WW  = 32,
  parameter int WF  = 21,
  parameter int MUW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            mode,
  input  logic [MUW-1:0]  mu,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [N*XW-1:0] XSTATE,
  input  logic [WW-1:0]   y_true,
  input  logic            w_clear,
  output logic [WW-1:0]   est,
  output logic            est_valid,
  output logic [N*WW-1:0] W_out,
  output logic            busy,
  output logic            sat_flag
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = XW + WW;
  localparam int AW = PW + IW;
  localparam int SW = AW + MUW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (N < 2 || XF >= XW || WF >= WW) begin : g_param_check
    $error("rdout_lms_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_ERR, S_UPD, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx;
  logic                   accept;
  logic                   mode_lat;
  logic [MUW-1:0]         mu_lat;
  logic signed [XW-1:0]   x_lat [N];
  logic signed [WW-1:0]   w [N];
  logic signed [WW-1:0]   y_lat, est_hold, e_s;
  logic signed [AW-1:0]   acc;

  logic signed [PW-1:0]     dot_prod, upd_prod, upd_d;
  logic signed [AW-1:0]     acc_sh;
  logic signed [WW:0]       diff;
  logic signed [WW-1:0]     est_val, err_val;
  logic signed [WW+MUW:0]   err_mu, err_sh;
  logic signed [PW:0]       w_sum;
  logic [WW:0]              est_s, err_s, es_s, w_s;

  // Clamp to WW bits; MSB of the result flags that a clamp happened.
  function automatic logic [WW:0] sat_ww(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] max_v, min_v;
    max_v = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    min_v = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};
    if (v > max_v)      return {2'b10, {(WW-1){1'b1}}};
    else if (v < min_v) return {2'b11, {(WW-1){1'b0}}};
    else                return {1'b0, v[WW-1:0]};
  endfunction

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    busy      = 1'b1;
    est_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy    = 1'b0;
        x_ready = !w_clear;
        if (x_valid && !w_clear) state_nxt = S_DOT;
      end
      S_DOT:   if (idx == LAST) state_nxt = S_ERR;
      S_ERR:   state_nxt = mode_lat ? S_UPD : S_DONE;
      S_UPD:   if (idx == LAST) state_nxt = S_DONE;
      S_DONE: begin
        est_valid = ce;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = ce && x_valid && x_ready;

  // Shared arithmetic: DOT uses dot_prod, ERR the est/err/e_s chain, UPD the w_sum path.
  always_comb begin
    dot_prod = PW'(x_lat[idx]) * PW'(w[idx]);
    acc_sh   = acc >>> XF;
    est_s    = sat_ww(SW'(acc_sh));
    est_val  = est_s[WW-1:0];
    diff     = {y_lat[WW-1], y_lat} - {est_val[WW-1], est_val};
    err_s    = sat_ww(SW'(diff));
    err_val  = err_s[WW-1:0];
    err_mu   = (WW+MUW+1)'(err_val) * (WW+MUW+1)'($signed({1'b0, mu_lat}));
    err_sh   = err_mu >>> MUW;
    es_s     = sat_ww(SW'(err_sh));
    upd_prod = PW'(e_s) * PW'(x_lat[idx]);
    upd_d    = upd_prod >>> XF;
    w_sum    = (PW+1)'(w[idx]) + (PW+1)'(upd_d);
    w_s      = sat_ww(SW'(w_sum));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      sat_flag <= 1'b0;
      est      <= '0;
      for (int i = 0; i < N; i++) w[i] <= '0;
    end else if (ce) begin
      state <= state_nxt;
      idx   <= ((state == S_DOT || state == S_UPD) && idx != LAST) ? idx + IW'(1) : '0;
      case (state)
        S_IDLE: if (w_clear) begin
          for (int i = 0; i < N; i++) w[i] <= '0;
          sat_flag <= 1'b0;
        end
        S_ERR: begin
          if (est_s[WW] || err_s[WW] || es_s[WW]) sat_flag <= 1'b1;
          if (!mode_lat) est <= est_val;
        end
        S_UPD: begin
          w[idx] <= w_s[WW-1:0];
          if (w_s[WW]) sat_flag <= 1'b1;
          if (idx == LAST) est <= est_hold;
        end
        default: ;
      endcase
    end
  end

  // Operand latches and accumulator carry no reset; acc is cleared on accept.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (accept) begin
        for (int i = 0; i < N; i++) x_lat[i] <= XSTATE[i*XW +: XW];
        y_lat    <= y_true;
        mode_lat <= mode;
        mu_lat   <= mu;
        acc      <= '0;
      end else if (state == S_DOT) begin
        acc <= acc + AW'(dot_prod);
      end
      if (state == S_ERR) begin
        est_hold <= est_val;
        e_s      <= es_s[WW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) W_out[i*WW +: WW] = w[i];
  end

endmodule
